// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter must reach WIDTH-1 without wrapping.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/fadd.sv
// One-bit full adder cell used as the serial datapath stage.
module fadd (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit per clock through a single fadd cell,
// framed by a start/busy/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             last;
   logic             bit_sum;
   logic             bit_cout;

   fadd u_fadd (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (carry),
      .sum  (bit_sum),
      .cout (bit_cout)
   );

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
         end else if (state == RUN) begin
            // LSB-first: each new sum bit enters at the top and drifts down.
            sum   <= (sum >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= bit_cout;
            cnt   <= cnt + CW'(1);
            if (last) cout <= bit_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 vector table and corner sequences, WIDTH=3 exhaustive sweep.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       start3 = 1'b0;
   logic [2:0] a3 = '0, b3 = '0;
   logic       cin3 = 1'b0;
   logic       busy3, done3, cout3;
   logic [2:0] sum3;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int bcnt8 = 0;
   logic prev_done8 = 1'b0;
   logic [8:0] q8[$];
   logic [3:0] q3[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;
   vec_t vecs[8];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         bcnt8 = 0;
      end else begin
         if (busy8) bcnt8++;
         if (done8) begin
            if (prev_done8) check("done8_one_cycle", done8, 1'b0);
            if (q8.size() == 0) begin
               check("done8_unexpected", done8, 1'b0);
            end else begin
               check("result8", {cout8, sum8}, q8.pop_front());
               check("busy8_cycles", bcnt8, 8);
            end
            bcnt8 = 0;
         end
      end
      prev_done8 = done8;
   end

   always @(negedge clk) begin
      if (!rst && done3) begin
         if (q3.size() == 0) check("done3_unexpected", done3, 1'b0);
         else check("result3", {cout3, sum3}, q3.pop_front());
      end
   end

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec, input int poke);
      int k;
      q8.push_back({ec, es});
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      check("busy8_after_accept", busy8, 1'b1);
      k = 0;
      while (!done8 && k < 40) begin
         if (k == poke) begin
            start8 = 1'b1; a8 = ~ta; b8 = 8'h77; cin8 = ~tc;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start8 = 1'b0;
      check("latency8", k, 8);
      @(negedge clk);
      check("done8_drop", done8, 1'b0);
      check("busy8_idle", busy8, 1'b0);
      check("hold8", {cout8, sum8}, {ec, es});
   endtask

   task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic tc);
      int k;
      q3.push_back({1'b0, ta} + {1'b0, tb} + {3'b000, tc});
      a3 = ta; b3 = tb; cin3 = tc; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      k = 0;
      while (!done3 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("latency3", k, 3);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

      #1 rst = 1'b1;
      #1;
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_result", {cout8, sum8}, 9'h000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, -1);

      // start re-pulsed mid-RUN with other operands must be ignored
      op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
      op8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 6);

      begin
         logic [7:0] ba[3] = '{8'h10, 8'hC8, 8'h01};
         logic [7:0] bb[3] = '{8'h20, 8'h40, 8'hFE};
         logic       bc[3] = '{1'b1, 1'b0, 1'b1};
         int k;
         int last_cyc;
         last_cyc = 0;
         start8 = 1'b1;
         for (int i = 0; i < 3; i++) begin
            a8 = ba[i]; b8 = bb[i]; cin8 = bc[i];
            q8.push_back({1'b0, ba[i]} + {1'b0, bb[i]} + {8'h00, bc[i]});
            @(negedge clk);
            k = 0;
            while (!done8 && k < 40) begin
               @(negedge clk);
               k++;
            end
            check("b2b_latency8", k, 8);
            if (i > 0) check("b2b_period8", cyc - last_cyc, 9);
            last_cyc = cyc;
         end
         start8 = 1'b0;
         @(negedge clk);
         check("b2b_done8_drop", done8, 1'b0);
      end

      a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("partial8", sum8, 8'hE0);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy8, 1'b0);
      check("abort_done", done8, 1'b0);
      check("abort_result", {cout8, sum8}, 9'h000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_quiet_busy", busy8, 1'b0);
      op8(8'hA7, 8'h6B, 1'b1, 8'h13, 1'b1, -1);

      for (int v = 0; v < 128; v++) begin
         logic [6:0] bits;
         bits = 7'(v);
         op3(bits[6:4], bits[3:1], bits[0]);
      end
      repeat (3) @(negedge clk);

      check("queue8_drained", q8.size(), 0);
      check("queue3_drained", q3.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
